debug_scan_ctrl: RTL
====================

DEBUG_SCAN_CTRL -- requirements
Module: debug_scan_ctrl

Interface
REQ-001 Parameter SCAN_LAST, default 6'd63, last debug address visited by a scan.
REQ-002 Parameter SETTLE_CYCLES, default 1, range 1..15, cycles debug_addr is held before capture.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 run_mode  in  1  1 = CPU free-runs; 0 = CPU halted, single-step allowed.
REQ-006 step_req  in  1  single-cycle pulse requesting one CPU clock-enable cycle.
REQ-007 scan_start  in  1  single-cycle pulse starting a full debug scan.
REQ-008 scan_abort  in  1  terminates an active scan.
REQ-009 sw_addr  in  6  manual debug address, used while idle.
REQ-010 debug_addr  out  6  address driven to the debug datapath/register mux.
REQ-011 debug_data  in  32  word returned by the debug mux for debug_addr.
REQ-012 rd_valid / rd_ready  out/in  1/1  capture stream handshake; transfer when both are high at an edge.
REQ-013 rd_data  out  32  captured word; rd_index  out  6  its address.
REQ-014 cpu_en  out  1  pipeline clock enable.
REQ-015 busy  out  1; scan_done  out  1 (one-cycle pulse); step_count  out  16.

Function
REQ-016 States: IDLE, SETTLE, CAPTURE, OUT, STEP.
REQ-017 IDLE: debug_addr is sw_addr registered each cycle; busy=0; rd_valid=0.
REQ-018 IDLE + scan_start: next state SETTLE, debug_addr=0, busy=1; scan_start while busy is ignored.
REQ-019 SETTLE: hold debug_addr for exactly SETTLE_CYCLES cycles, then go to CAPTURE.
REQ-020 CAPTURE: in one cycle, rd_data<=debug_data, rd_index<=debug_addr, rd_valid<=1, next state OUT.
REQ-021 OUT: rd_valid, rd_data and rd_index stay stable until the rd_ready handshake completes.
REQ-022 On handshake with debug_addr<SCAN_LAST: rd_valid<=0, debug_addr increments by 1, next state SETTLE.
REQ-023 On handshake with debug_addr==SCAN_LAST: rd_valid<=0, scan_done pulses for 1 cycle, next state IDLE; debug_addr never wraps past SCAN_LAST.
REQ-024 Latency: first rd_valid is SETTLE_CYCLES+2 cycles after scan_start is sampled; with rd_ready held high, one word per SETTLE_CYCLES+2 cycles.
REQ-025 scan_abort sampled high in SETTLE/CAPTURE/OUT: next state IDLE; rd_valid drops with no handshake and scan_done is not pulsed. This is the only case where rd_valid drops without a handshake.
REQ-026 scan_abort coincident with the final handshake: the abort wins and scan_done is not pulsed.
REQ-027 cpu_en=0 in SETTLE, CAPTURE and OUT for any run_mode, so the pipeline is frozen during a scan.
REQ-028 In IDLE, cpu_en=run_mode.
REQ-029 IDLE, run_mode=0, step_req=1, scan_start=0: next state STEP.
REQ-030 STEP: cpu_en=1 for exactly one cycle, step_count increments (wraps 16'hFFFF->0), then IDLE.
REQ-031 step_req is ignored when run_mode=1 or when not in IDLE.
REQ-032 scan_start and step_req coincident in IDLE: the scan starts and the step is dropped.

Reset
REQ-033 While rst_n=0, asynchronously: state=IDLE, debug_addr=0, rd_valid=0, rd_data=0, rd_index=0, cpu_en=0, busy=0, scan_done=0, step_count=0.
REQ-034 Reset asserted mid-scan or mid-step discards the operation.
REQ-035 After reset release, the first edge behaves as IDLE.

Configuration
REQ-036 With macro DEBUG_SCAN_SKIP_RSV_EN defined, the increment step skips addresses 56..63 (unpopulated datapath slots): from 55 it goes directly to scan end. A scan ends at min(SCAN_LAST,55).
REQ-037 Without DEBUG_SCAN_SKIP_RSV_EN, every address 0..SCAN_LAST is visited.

Verification
REQ-038 Reset mid-OUT with rd_valid=1 -> all outputs zero immediately; scan_start after release -> rd_index=0 delivered first.
REQ-039 SETTLE_CYCLES=1, rd_ready=1, mux model returns {26'b0,addr}, scan_start at cycle 0 -> rd_valid at cycle 3; 64 words 0..63 in order, one per 3 cycles; scan_done one cycle after word 63; cpu_en=0 throughout.
REQ-040 rd_ready held 0 for 10 cycles on word 5 -> rd_data=5 and rd_index=5 stable, debug_addr=5, no increment until rd_ready=1.
REQ-041 scan_abort during word 20 OUT -> IDLE next cycle, rd_valid=0, no scan_done, debug_addr follows sw_addr=6'h2A.
REQ-042 run_mode=0, three step_req pulses, one coincident with scan_start -> two one-cycle cpu_en pulses, step_count=2; run_mode=1 step_req -> ignored, cpu_en=1.
REQ-043 DEBUG_SCAN_SKIP_RSV_EN defined, SCAN_LAST=63 -> last rd_index=55, scan_done after word 55, 56 words total.

Source files
------------

// File: rtl/debug_scan_ctrl_if.sv
// rtl/debug_scan_ctrl_if.sv - debug mux address/data and capture stream bundle
interface debug_scan_ctrl_if;
    logic [5:0]  debug_addr;
    logic [31:0] debug_data;
    logic        rd_valid;
    logic        rd_ready;
    logic [31:0] rd_data;
    logic [5:0]  rd_index;

    modport master (
        output debug_addr,
        input  debug_data,
        output rd_valid,
        input  rd_ready,
        output rd_data,
        output rd_index
    );

    modport slave (
        input  debug_addr,
        output debug_data,
        input  rd_valid,
        output rd_ready,
        input  rd_data,
        input  rd_index
    );
endinterface

// File: rtl/debug_scan_ctrl.sv
// rtl/debug_scan_ctrl.sv - debug register scan and CPU single-step controller
// Optional DEBUG_SCAN_SKIP_RSV_EN ends every scan at min(SCAN_LAST, 55).
module debug_scan_ctrl #(
    parameter logic [5:0] SCAN_LAST     = 6'd63,
    parameter int         SETTLE_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run_mode,
    input  logic              step_req,
    input  logic              scan_start,
    input  logic              scan_abort,
    input  logic [5:0]        sw_addr,
    debug_scan_ctrl_if.master dbg,
    output logic              cpu_en,
    output logic              busy,
    output logic              scan_done,
    output logic [15:0]       step_count
);

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        CAPTURE,
        OUT,
        STEP
    } state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

`ifdef DEBUG_SCAN_SKIP_RSV_EN
    // Slots 56..63 are unpopulated, so the scan never enters them.
    localparam logic [5:0] END_ADDR = (SCAN_LAST > 6'd55) ? 6'd55 : SCAN_LAST;
`else
    localparam logic [5:0] END_ADDR = SCAN_LAST;
`endif

    state_t     state;
    logic [3:0] settle_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            settle_cnt     <= '0;
            dbg.debug_addr <= '0;
            dbg.rd_valid   <= 1'b0;
            dbg.rd_data    <= '0;
            dbg.rd_index   <= '0;
            cpu_en         <= 1'b0;
            busy           <= 1'b0;
            scan_done      <= 1'b0;
            step_count     <= '0;
        end else begin
            scan_done <= 1'b0;
            // Abort outranks everything in a scan, including the final handshake.
            if (scan_abort && (state inside {SETTLE, CAPTURE, OUT})) begin
                state          <= IDLE;
                dbg.rd_valid   <= 1'b0;
                dbg.debug_addr <= sw_addr;
                busy           <= 1'b0;
                cpu_en         <= run_mode;
            end else begin
                case (state)
                    IDLE: begin
                        if (scan_start) begin
                            state          <= SETTLE;
                            settle_cnt     <= '0;
                            dbg.debug_addr <= '0;
                            busy           <= 1'b1;
                            cpu_en         <= 1'b0;
                        end else if (step_req && !run_mode) begin
                            state          <= STEP;
                            dbg.debug_addr <= sw_addr;
                            busy           <= 1'b0;
                            cpu_en         <= 1'b1;
                        end else begin
                            dbg.debug_addr <= sw_addr;
                            busy           <= 1'b0;
                            cpu_en         <= run_mode;
                        end
                    end

                    SETTLE: begin
                        cpu_en <= 1'b0;
                        if (settle_cnt == SETTLE_LAST) begin
                            state <= CAPTURE;
                        end else begin
                            settle_cnt <= settle_cnt + 4'd1;
                        end
                    end

                    CAPTURE: begin
                        cpu_en       <= 1'b0;
                        dbg.rd_data  <= dbg.debug_data;
                        dbg.rd_index <= dbg.debug_addr;
                        dbg.rd_valid <= 1'b1;
                        state        <= OUT;
                    end

                    OUT: begin
                        if (dbg.rd_ready) begin
                            dbg.rd_valid <= 1'b0;
                            if (dbg.debug_addr < END_ADDR) begin
                                dbg.debug_addr <= dbg.debug_addr + 6'd1;
                                settle_cnt     <= '0;
                                state          <= SETTLE;
                                cpu_en         <= 1'b0;
                            end else begin
                                dbg.debug_addr <= sw_addr;
                                scan_done      <= 1'b1;
                                busy           <= 1'b0;
                                cpu_en         <= run_mode;
                                state          <= IDLE;
                            end
                        end else begin
                            cpu_en <= 1'b0;
                        end
                    end

                    STEP: begin
                        step_count     <= step_count + 16'd1;
                        dbg.debug_addr <= sw_addr;
                        cpu_en         <= run_mode;
                        busy           <= 1'b0;
                        state          <= IDLE;
                    end

                    default: begin
                        state        <= IDLE;
                        dbg.rd_valid <= 1'b0;
                        busy         <= 1'b0;
                        cpu_en       <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
